// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: handshake/bus bundle for rr_arb_mux.
//   in_data/in_valid/in_ready : N producer channels, channel i at [i*WIDTH +: WIDTH]
//   mode/sel                  : selection control (0 = fixed sel, 1 = round-robin)
//   out_data/out_valid/out_ready/out_src : registered output and its source index
// slave modport is the mux side, master modport is the producer/consumer side.
`timescale 1ns/1ps
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_src;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input WIDTH-bit mux with a single registered output stage and
// valid/ready on every input and on the output. Selection is either a fixed
// external index (mode=0) or round-robin arbitration (mode=1).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arb_mux_if.slave (inputs, selection control, registered output)
`timescale 1ns/1ps
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int SEL_W = $clog2(N);

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] gnt_data;
  logic [N-1:0]     in_ready;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  // The output register can take a word when empty or when its word retires now.
  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin : grant_logic
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    if (!bus.mode) begin
      // Out-of-range sel (possible when N is not a power of two) never grants.
      if (int'(bus.sel) < N) begin
        if (bus.in_valid[bus.sel]) begin
          gnt_vld = 1'b1;
          gnt     = bus.sel;
        end
      end
    end else begin
      // Scan from ptr upward with explicit wrap so any N works.
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_vld && bus.in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_en && gnt_vld && (gnt == SEL_W'(i));
    end
  end

  always_comb begin
    gnt_data = bus.in_data[int'(gnt)*WIDTH +: WIDTH];
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (gnt_vld) begin
        out_data_d  = gnt_data;
        out_src_d   = gnt;
        out_valid_d = 1'b1;
        if (bus.mode) begin
          ptr_d = (gnt == SEL_W'(N-1)) ? '0 : gnt + 1'b1;
        end
      end else begin
        // Nothing to load: drop valid but keep the last word/source visible.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: self-checking bench for rr_arb_mux (N=4 and N=3 instances,
// WIDTH=8). Table of per-cycle vectors plus hand sequences for backpressure,
// mid-stream reset and pointer wrap; N=4 output words go through a scoreboard.
`timescale 1ns/1ps
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(8), .N(4)) if4 ();
  rr_arb_mux_if #(.WIDTH(8), .N(3)) if3 ();

  rr_arb_mux #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  rr_arb_mux #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] v;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [1:0] exp_src;
  } vec_t;
  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One negedge of the bench: scoreboard the handshakes that the next edge commits.
  task automatic tick_neg();
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (if4.out_valid && if4.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_dup: out_data %0h accepted with nothing expected", if4.out_data);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_data", 32'(if4.out_data), 32'(sb_e.d));
          chk("sb_src", 32'(if4.out_src), 32'(sb_e.s));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (if4.in_ready[i]) begin
          chk("ready_implies_valid", 32'(if4.in_valid[i]), 32'd1);
          sb_q.push_back('{d: if4.in_data[i*8 +: 8], s: 2'(i)});
        end
      end
    end
  endtask

  task automatic tick_pos();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] d3_exp[4];
  int         src3_exp[4];

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[2]  = '{1'b0, 2'd0, 4'b1110, 4'b0000, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0, 2'd3};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 4'b1000, 1'b1, 2'd3};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 4'b0010, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 2'd0, 4'b1010, 4'b1000, 1'b1, 2'd3};
    vecs[12] = '{1'b1, 2'd0, 4'b1010, 4'b0010, 1'b1, 2'd1};
    vecs[13] = '{1'b1, 2'd0, 4'b1010, 4'b1000, 1'b1, 2'd3};
    vecs[14] = '{1'b1, 2'd0, 4'b1010, 4'b0010, 1'b1, 2'd1};
    vecs[15] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd1};
    vecs[16] = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[17] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1, 2'd0};
    vecs[18] = '{1'b1, 2'd0, 4'b1111, 4'b0010, 1'b1, 2'd1};

    d3_exp[0] = 8'h11; src3_exp[0] = 0;
    d3_exp[1] = 8'h22; src3_exp[1] = 1;
    d3_exp[2] = 8'h33; src3_exp[2] = 2;
    d3_exp[3] = 8'h11; src3_exp[3] = 0;

    if4.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    if4.in_valid  = 4'b0000;
    if4.mode      = 1'b0;
    if4.sel       = 2'd0;
    if4.out_ready = 1'b1;
    if3.in_data   = {8'h33, 8'h22, 8'h11};
    if3.in_valid  = 3'b000;
    if3.mode      = 1'b0;
    if3.sel       = 2'd0;
    if3.out_ready = 1'b1;

    // Reset state
    tick_neg();
    chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
    chk("rst_out_data", 32'(if4.out_data), 32'd0);
    chk("rst_out_src", 32'(if4.out_src), 32'd0);
    chk("rst_in_ready", 32'(if4.in_ready), 32'd0);
    tick_pos();
    rst_n = 1'b1;

    // Table-driven per-cycle vectors (N=4, out_ready held high)
    for (int r = 0; r < 19; r++) begin
      if4.mode     = vecs[r].mode;
      if4.sel      = vecs[r].sel;
      if4.in_valid = vecs[r].v;
      tick_neg();
      chk($sformatf("vec%0d_in_ready", r), 32'(if4.in_ready), 32'(vecs[r].exp_ir));
      tick_pos();
      chk($sformatf("vec%0d_out_valid", r), 32'(if4.out_valid), 32'(vecs[r].exp_ov));
      chk($sformatf("vec%0d_out_src", r), 32'(if4.out_src), 32'(vecs[r].exp_src));
    end

    // Backpressure: hold 8'h22 for three stalled cycles, then release
    if4.mode = 1'b0; if4.sel = 2'd1; if4.in_valid = 4'b1111; if4.out_ready = 1'b1;
    tick_neg();
    tick_pos();
    chk("bp_load_data", 32'(if4.out_data), 32'h22);
    if4.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick_neg();
      chk("bp_stall_in_ready", 32'(if4.in_ready), 32'd0);
      chk("bp_stall_data", 32'(if4.out_data), 32'h22);
      chk("bp_stall_valid", 32'(if4.out_valid), 32'd1);
      tick_pos();
    end
    if4.out_ready = 1'b1; if4.sel = 2'd3;
    tick_neg();
    chk("bp_release_in_ready", 32'(if4.in_ready), 32'b1000);
    tick_pos();
    chk("bp_next_data", 32'(if4.out_data), 32'h44);
    chk("bp_next_src", 32'(if4.out_src), 32'd3);
    if4.in_valid = 4'b0000;
    tick_neg();
    chk("bp_drain_in_ready", 32'(if4.in_ready), 32'd0);
    tick_pos();
    chk("bp_drain_valid", 32'(if4.out_valid), 32'd0);
    chk("sb_empty_after_drain", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset mid-stream, then first round-robin grant is channel 0
    if4.mode = 1'b1; if4.in_valid = 4'b1111; if4.out_ready = 1'b1;
    tick_neg();
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(if4.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(if4.out_valid), 32'd0);
    chk("async_rst_data", 32'(if4.out_data), 32'd0);
    chk("async_rst_src", 32'(if4.out_src), 32'd0);
    tick_neg();
    chk("in_rst_in_ready", 32'(if4.in_ready), 32'b0001);
    tick_pos();
    rst_n = 1'b1;
    tick_neg();
    chk("post_rst_in_ready", 32'(if4.in_ready), 32'b0001);
    tick_pos();
    chk("post_rst_src", 32'(if4.out_src), 32'd0);
    chk("post_rst_data", 32'(if4.out_data), 32'h11);
    tick_neg();
    chk("post_rst_in_ready2", 32'(if4.in_ready), 32'b0010);
    tick_pos();
    if4.in_valid = 4'b0000;
    tick_neg();
    tick_pos();
    tick_neg();
    tick_pos();

    // N=3 round-robin wrap 2->0, then out-of-range sel never grants
    if3.mode = 1'b1; if3.in_valid = 3'b111; if3.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick_neg();
      chk($sformatf("n3_rr%0d_in_ready", k), 32'(if3.in_ready), 32'(1 << src3_exp[k]));
      tick_pos();
      chk($sformatf("n3_rr%0d_src", k), 32'(if3.out_src), 32'(src3_exp[k]));
      chk($sformatf("n3_rr%0d_data", k), 32'(if3.out_data), 32'(d3_exp[k]));
    end
    if3.mode = 1'b0; if3.sel = 2'd3;
    tick_neg();
    chk("n3_sel3_in_ready", 32'(if3.in_ready), 32'd0);
    tick_pos();
    chk("n3_sel3_valid", 32'(if3.out_valid), 32'd0);
    chk("n3_sel3_src_held", 32'(if3.out_src), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
